apogee_pit: RTL

Three-channel programmable interval timer (K580VI53 / i8253 subset) for the Apogee BK-01 core. It is decoded at EC00–ECFF and is the source of the data the CPU read mux currently returns as 8'h00 for that page. Its three OUT lines feed the sound mixer alongside the PPA1 PC0 beeper bit. Counters advance on a count-enable strobe derived from clk_sys. Binary counting only.

---
 rtl/apogee_pit_if.sv | 16 +
 rtl/apogee_pit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apogee_pit_if.sv
// apogee_pit_if: CPU-side register bus of the three-channel interval timer.
//   addr  - register select (0..2 counters, 3 control word)
//   din   - CPU write data
//   we_n  - write strobe, active-low, held for many clk_sys cycles
//   rd_n  - read strobe, active-low, held for many clk_sys cycles
//   dout  - read data, combinational from addr and read state
interface apogee_pit_if;
  logic [1:0] addr;
  logic [7:0] din;
  logic       we_n;
  logic       rd_n;
  logic [7:0] dout;

  modport master (output addr, output din, output we_n, output rd_n, input dout);
  modport slave  (input addr, input din, input we_n, input rd_n, output dout);
endinterface

// File: rtl/apogee_pit.sv
// apogee_pit: three-channel programmable interval timer (i8253 subset,
// binary counting, modes 0/2/3) for the Apogee BK-01 EC00-ECFF page.
//   clk_sys - system clock, all state on rising edge
//   RESET   - synchronous active-low reset
//   clk_en  - shared one-cycle count tick
//   bus     - CPU register bus (apogee_pit_if.slave)
//   gate    - per-counter GATE inputs
//   out     - per-counter OUT lines, registered
module apogee_pit (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          clk_en,
  apogee_pit_if.slave   bus,
  input  logic [2:0]    gate,
  output logic [2:0]    out
);

  // IDLE: waiting for a count; LOAD: CR complete (or gate re-armed), CE
  // takes CR at the next tick; RUN: counting.
  typedef enum logic [1:0] {CNT_IDLE, CNT_LOAD, CNT_RUN} cnt_state_e;

  logic [15:0] ce_q   [3];
  logic [15:0] ce_d   [3];
  logic [15:0] cr_q   [3];
  logic [15:0] cr_d   [3];
  logic [15:0] ol_q   [3];
  logic [15:0] ol_d   [3];
  logic [15:0] half_q [3];
  logic [15:0] half_d [3];
  logic [7:0]  lsb_q  [3];
  logic [7:0]  lsb_d  [3];
  logic [2:0]  mode_q [3];
  logic [2:0]  mode_d [3];
  logic [1:0]  rw_q   [3];
  logic [1:0]  rw_d   [3];
  cnt_state_e  st_q   [3];
  cnt_state_e  st_d   [3];
  logic [2:0]  wtog_q, wtog_d;
  logic [2:0]  rtog_q, rtog_d;
  logic [2:0]  lat_q, lat_d;
  logic [2:0]  out_q, out_d;
  logic        we_n_q, rd_n_q;

  logic        we_ev, rd_ev;
  logic [2:0]  ctl_sel, cnt_sel, rd_sel, cr_done, first_byte;
  logic [15:0] ce_dec [3];
  logic [2:0]  ctl_mode;
  logic [15:0] rd_src;
  logic        rd_msb;
  logic        unused_bcd;

  assign unused_bcd = bus.din[0];
  assign out        = out_q;
  // Modes 6/7 are aliases of 2/3.
  assign ctl_mode   = (bus.din[3:2] == 2'b11) ? {1'b0, bus.din[2:1]} : bus.din[3:1];

  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < 3; i++) begin
        ce_q[i]   <= '0;
        cr_q[i]   <= '0;
        ol_q[i]   <= '0;
        half_q[i] <= '0;
        lsb_q[i]  <= '0;
        mode_q[i] <= '0;
        rw_q[i]   <= '0;
        st_q[i]   <= CNT_IDLE;
      end
      wtog_q <= '0;
      rtog_q <= '0;
      lat_q  <= '0;
      out_q  <= '1;
      we_n_q <= 1'b1;
      rd_n_q <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        ce_q[i]   <= ce_d[i];
        cr_q[i]   <= cr_d[i];
        ol_q[i]   <= ol_d[i];
        half_q[i] <= half_d[i];
        lsb_q[i]  <= lsb_d[i];
        mode_q[i] <= mode_d[i];
        rw_q[i]   <= rw_d[i];
        st_q[i]   <= st_d[i];
      end
      wtog_q <= wtog_d;
      rtog_q <= rtog_d;
      lat_q  <= lat_d;
      out_q  <= out_d;
      we_n_q <= bus.we_n;
      rd_n_q <= bus.rd_n;
    end
  end

  always_comb begin
    we_ev      = ~bus.we_n & we_n_q;
    rd_ev      = bus.rd_n & ~rd_n_q;
    ctl_sel    = '0;
    cnt_sel    = '0;
    rd_sel     = '0;
    cr_done    = '0;
    first_byte = '0;
    wtog_d     = wtog_q;
    rtog_d     = rtog_q;
    lat_d      = lat_q;
    out_d      = out_q;
    for (int unsigned i = 0; i < 3; i++) begin
      ce_d[i]   = ce_q[i];
      cr_d[i]   = cr_q[i];
      ol_d[i]   = ol_q[i];
      half_d[i] = half_q[i];
      lsb_d[i]  = lsb_q[i];
      mode_d[i] = mode_q[i];
      rw_d[i]   = rw_q[i];
      st_d[i]   = st_q[i];
      ce_dec[i] = ce_q[i] - 16'd1;

      ctl_sel[i] = we_ev && (bus.addr == 2'd3) && (bus.din[7:6] == 2'(i));
      cnt_sel[i] = we_ev && (bus.addr == 2'(i));
      rd_sel[i]  = rd_ev && (bus.addr == 2'(i));

      // Gate low in modes 2/3 holds OUT high and re-arms a full reload.
      if ((mode_q[i] == 3'd2 || mode_q[i] == 3'd3) && !gate[i]) begin
        out_d[i] = 1'b1;
        if (st_q[i] == CNT_RUN) st_d[i] = CNT_LOAD;
      end

      // A control write to this counter suppresses its tick.
      if (clk_en && !ctl_sel[i]) begin
        case (mode_q[i])
          3'd0: begin
            if (st_q[i] == CNT_LOAD) begin
              ce_d[i] = cr_q[i];
              st_d[i] = CNT_RUN;
            end else if (st_q[i] == CNT_RUN && gate[i]) begin
              ce_d[i] = ce_dec[i];
              if (ce_q[i] == 16'd1) out_d[i] = 1'b1;
            end
          end
          3'd2, 3'd3: begin
            if (gate[i]) begin
              if (st_q[i] == CNT_LOAD || (st_q[i] == CNT_RUN && ce_q[i] == 16'd1)) begin
                ce_d[i]   = cr_q[i];
                // Mode 3 low phase is the last floor(N/2) ticks; N=0 means 65536.
                half_d[i] = (cr_q[i] == 16'd0) ? 16'h8000 : {1'b0, cr_q[i][15:1]};
                out_d[i]  = 1'b1;
                st_d[i]   = CNT_RUN;
              end else if (st_q[i] == CNT_RUN) begin
                ce_d[i] = ce_dec[i];
                if (mode_q[i] == 3'd2) begin
                  if (ce_q[i] == 16'd2) out_d[i] = 1'b0;
                end else begin
                  out_d[i] = (ce_dec[i] > half_q[i]);
                end
              end
            end
          end
          default: ;
        endcase
      end

      if (cnt_sel[i] && rw_q[i] != 2'b00) begin
        first_byte[i] = !(rw_q[i] == 2'b11 && wtog_q[i]);
        case (rw_q[i])
          2'b01: begin
            cr_d[i]    = {8'h00, bus.din};
            cr_done[i] = 1'b1;
          end
          2'b10: begin
            cr_d[i]    = {bus.din, 8'h00};
            cr_done[i] = 1'b1;
          end
          default: begin
            if (!wtog_q[i]) begin
              lsb_d[i]  = bus.din;
              wtog_d[i] = 1'b1;
            end else begin
              cr_d[i]    = {bus.din, lsb_q[i]};
              wtog_d[i]  = 1'b0;
              cr_done[i] = 1'b1;
            end
          end
        endcase
        if (mode_q[i] == 3'd0) begin
          if (first_byte[i]) out_d[i] = 1'b0;
          st_d[i] = cr_done[i] ? CNT_LOAD : CNT_IDLE;
        end else if (cr_done[i] && st_q[i] == CNT_IDLE) begin
          st_d[i] = CNT_LOAD;
        end
      end

      if (rd_sel[i]) begin
        if (rw_q[i] == 2'b11) begin
          rtog_d[i] = ~rtog_q[i];
          if (rtog_q[i]) lat_d[i] = 1'b0;
        end else begin
          lat_d[i] = 1'b0;
        end
      end

      if (ctl_sel[i]) begin
        if (bus.din[5:4] == 2'b00) begin
          if (!lat_q[i]) begin
            ol_d[i]  = ce_q[i];
            lat_d[i] = 1'b1;
          end
        end else begin
          rw_d[i]   = bus.din[5:4];
          mode_d[i] = ctl_mode;
          wtog_d[i] = 1'b0;
          rtog_d[i] = 1'b0;
          lat_d[i]  = 1'b0;
          st_d[i]   = CNT_IDLE;
          out_d[i]  = (ctl_mode != 3'd0);
        end
      end
    end
  end

  always_comb begin
    bus.dout = 8'hFF;
    rd_src   = '0;
    rd_msb   = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bus.addr == 2'(i)) begin
        rd_src   = lat_q[i] ? ol_q[i] : ce_q[i];
        rd_msb   = (rw_q[i] == 2'b10) || (rw_q[i] == 2'b11 && rtog_q[i]);
        bus.dout = rd_msb ? rd_src[15:8] : rd_src[7:0];
      end
    end
  end

endmodule
